// File: rtl/reg_scoreboard.sv
// ID-stage register scoreboard: per-register writeback countdowns drive the RAW stall,
// a drain barrier for buffer-wait instructions, and a saturating stall-cycle counter.
module reg_scoreboard #(
  parameter int REG_COUNT = 32,
  parameter int ADDR_W    = 5,
  parameter int LAT_W     = 3,
  parameter int CNT_W     = 16
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 id_valid,
  input  logic                 id_kill,
  input  logic [ADDR_W-1:0]    id_rs,
  input  logic [ADDR_W-1:0]    id_rt,
  input  logic                 id_use_rs,
  input  logic                 id_use_rt,
  input  logic                 id_regwrite,
  input  logic [ADDR_W-1:0]    id_rd,
  input  logic [LAT_W-1:0]     id_latency,
  input  logic                 id_barrier,
  input  logic                 barrier_ready,
  output logic                 id_stall,
  output logic [REG_COUNT-1:0] pending_mask,
  output logic                 busy_any,
  output logic [CNT_W-1:0]     stall_count
);

  logic [LAT_W-1:0] count_p1 [REG_COUNT];
  logic             raw_rs;
  logic             raw_rt;
  logic             bar;
  logic             issue;

  function automatic logic [LAT_W-1:0] dec_sat(input logic [LAT_W-1:0] c);
    return (c == '0) ? '0 : c - 1'b1;
  endfunction

  function automatic logic [LAT_W-1:0] lat_max(input logic [LAT_W-1:0] a,
                                               input logic [LAT_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Register 0 is never tracked; indices >= REG_COUNT never match any entry.
  always_comb begin
    pending_mask = '0;
    raw_rs       = 1'b0;
    raw_rt       = 1'b0;
    for (int r = 1; r < REG_COUNT; r++) begin
      pending_mask[r] = |count_p1[r];
      if (id_rs == ADDR_W'(r) && pending_mask[r]) raw_rs = 1'b1;
      if (id_rt == ADDR_W'(r) && pending_mask[r]) raw_rt = 1'b1;
    end
    busy_any = |pending_mask;
    bar      = id_barrier & (busy_any | ~barrier_ready);
    id_stall = id_valid & ~id_kill & ((id_use_rs & raw_rs) | (id_use_rt & raw_rt) | bar);
    issue    = id_valid & ~id_kill & ~id_stall;
  end

  // Stage p1: countdown update; max() keeps a longer older write alive on WAW.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int r = 0; r < REG_COUNT; r++) count_p1[r] <= '0;
      stall_count <= '0;
    end else begin
      for (int r = 0; r < REG_COUNT; r++) begin
        if (issue && id_regwrite && (r != 0) && (id_rd == ADDR_W'(r)) && (id_latency != '0))
          count_p1[r] <= lat_max(dec_sat(count_p1[r]), id_latency);
        else
          count_p1[r] <= dec_sat(count_p1[r]);
      end
      if (id_stall) stall_count <= sat_inc(stall_count);
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard with hand-computed stall/mask/counter expectations.
module tb_reg_scoreboard;
  localparam int RC = 24;
  localparam int AW = 5;
  localparam int LW = 3;
  localparam int CW = 4;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          id_valid, id_kill, id_use_rs, id_use_rt, id_regwrite;
  logic          id_barrier, barrier_ready;
  logic [AW-1:0] id_rs, id_rt, id_rd;
  logic [LW-1:0] id_latency;
  logic          id_stall, busy_any;
  logic [RC-1:0] pending_mask;
  logic [CW-1:0] stall_count;

  int errors = 0;
  int checks = 0;

  always #5 Clk = ~Clk;

  reg_scoreboard #(.REG_COUNT(RC), .ADDR_W(AW), .LAT_W(LW), .CNT_W(CW)) dut (
    .Clk(Clk), .Rst(Rst), .id_valid(id_valid), .id_kill(id_kill),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_regwrite(id_regwrite), .id_rd(id_rd), .id_latency(id_latency),
    .id_barrier(id_barrier), .barrier_ready(barrier_ready), .id_stall(id_stall),
    .pending_mask(pending_mask), .busy_any(busy_any), .stall_count(stall_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic idle;
    id_valid = 0; id_kill = 0; id_use_rs = 0; id_use_rt = 0; id_regwrite = 0;
    id_barrier = 0; barrier_ready = 1; id_rs = 0; id_rt = 0; id_rd = 0; id_latency = 0;
  endtask

  task automatic do_reset;
    idle;
    Rst = 1;
    tick;
    Rst = 0;
  endtask

  task automatic issue_wr(input logic [AW-1:0] rd, input logic [LW-1:0] lat);
    idle;
    id_valid = 1; id_regwrite = 1; id_rd = rd; id_latency = lat;
  endtask

  task automatic reader(input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                        input logic urs, input logic urt);
    idle;
    id_valid = 1; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
  endtask

  initial begin
    idle;
    Rst = 1;
    tick; tick;
    Rst = 0;
    #1;
    chk("rst_mask", 32'(pending_mask), 0);
    chk("rst_busy", 32'(busy_any), 0);
    chk("rst_cnt", 32'(stall_count), 0);
    chk("rst_stall", 32'(id_stall), 0);

    // Basic RAW window with L=3
    do_reset;
    issue_wr(5, 3); #1;
    chk("t1_issue", 32'(id_stall), 0);
    tick;
    reader(5, 0, 1, 0);
    for (int c = 1; c <= 3; c++) begin
      #1;
      chk($sformatf("t1_stall_c%0d", c), 32'(id_stall), 1);
      chk($sformatf("t1_mask_c%0d", c), 32'(pending_mask), 32'h20);
      tick;
    end
    #1;
    chk("t1_issue_c4", 32'(id_stall), 0);
    chk("t1_mask_c4", 32'(pending_mask), 0);
    chk("t1_cnt", 32'(stall_count), 3);

    // WAW: longer older write survives a shorter younger one
    do_reset;
    issue_wr(7, 6); tick;
    issue_wr(7, 2); #1;
    chk("t2_waw_issue", 32'(id_stall), 0);
    tick;
    reader(7, 0, 1, 0);
    for (int c = 2; c <= 6; c++) begin
      #1;
      chk($sformatf("t2_stall_c%0d", c), 32'(id_stall), 1);
      tick;
    end
    #1;
    chk("t2_issue_c7", 32'(id_stall), 0);

    // r0 and out-of-range registers are never tracked; self-dependence does not stall
    do_reset;
    issue_wr(0, 5); tick;
    issue_wr(25, 5); tick;
    reader(0, 0, 1, 1); #1;
    chk("t3_r0_stall", 32'(id_stall), 0);
    chk("t3_mask", 32'(pending_mask), 0);
    chk("t3_busy", 32'(busy_any), 0);
    tick;
    reader(25, 25, 1, 1); #1;
    chk("t3_oor_stall", 32'(id_stall), 0);
    tick;
    issue_wr(6, 3); id_use_rs = 1; id_rs = 6; #1;
    chk("t3_self_dep", 32'(id_stall), 0);
    tick;
    reader(6, 0, 1, 0); #1;
    chk("t3_self_rec", 32'(id_stall), 1);

    // Barrier: wait for drain and barrier_ready
    do_reset;
    issue_wr(3, 2); tick;
    idle; id_valid = 1; id_barrier = 1; barrier_ready = 0;
    for (int c = 1; c <= 4; c++) begin
      #1;
      chk($sformatf("t4_stall_c%0d", c), 32'(id_stall), 1);
      chk($sformatf("t4_busy_c%0d", c), 32'(busy_any), (c < 3) ? 1 : 0);
      tick;
    end
    barrier_ready = 1; id_regwrite = 1; id_rd = 6; id_latency = 1; #1;
    chk("t4_issue_c5", 32'(id_stall), 0);
    tick;
    id_regwrite = 0; #1;
    chk("t4_bar_rec", 32'(pending_mask), 32'h40);
    chk("t4_bar_busy", 32'(id_stall), 1);
    tick;
    #1;
    chk("t4_c7_stall", 32'(id_stall), 0);
    chk("t4_cnt", 32'(stall_count), 5);

    // use_rt gating and kill
    do_reset;
    issue_wr(9, 4); tick;
    reader(0, 9, 0, 0); #1;
    chk("t5_nouse", 32'(id_stall), 0);
    tick;
    reader(0, 9, 0, 1); #1;
    chk("t5_use_rt", 32'(id_stall), 1);
    tick;
    reader(0, 9, 0, 1); id_kill = 1; id_regwrite = 1; id_rd = 10; id_latency = 3; #1;
    chk("t5_kill", 32'(id_stall), 0);
    tick;
    idle; #1;
    chk("t5_norec", 32'(pending_mask), 32'h200);
    tick;
    #1;
    chk("t5_drain", 32'(pending_mask), 0);
    chk("t5_cnt", 32'(stall_count), 1);

    // Reset mid-operation
    do_reset;
    issue_wr(4, 7); tick;
    idle; #1;
    chk("t6_mask", 32'(pending_mask), 32'h10);
    tick;
    reader(4, 0, 1, 0); Rst = 1; tick;
    Rst = 0; id_barrier = 1; barrier_ready = 1; #1;
    chk("t6_mask_clr", 32'(pending_mask), 0);
    chk("t6_stall", 32'(id_stall), 0);
    chk("t6_busy", 32'(busy_any), 0);
    chk("t6_cnt", 32'(stall_count), 0);

    // Stall counter saturation (CNT_W=4)
    do_reset;
    idle; id_valid = 1; id_barrier = 1; barrier_ready = 0;
    repeat (14) tick;
    #1;
    chk("t7_cnt14", 32'(stall_count), 14);
    repeat (6) tick;
    #1;
    chk("t7_sat", 32'(stall_count), 15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
